rfu_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: the ALU result path and the load-return (memory) path.
- Load returns are buffered in a small FIFO; ALU results are unbuffered and granted directly.
- The arbiter guarantees loads cannot starve and drives a registered write (we/addr/data) into the register file unit.

---
 rtl/rfu_wb_arbiter_if.sv | 46 ++++
 rtl/rfu_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rfu_wb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rfu_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters and the register-file write arbiter.
// Optional forwarding-lookup signals exist only when RFU_WB_FWD_EN is defined.
interface rfu_wb_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  q_count;
  logic              busy;
`ifdef RFU_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, fwd_raddr,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, q_count, busy, fwd_hit, fwd_data
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, fwd_raddr,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, q_count, busy, fwd_hit, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, q_count, busy
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, q_count, busy
  );
`endif
endinterface

// File: rtl/rfu_wb_arbiter.sv
// Register-file writeback arbiter: unbuffered ALU path vs. queued load returns with anti-starvation.
// Optional macro RFU_WB_FWD_EN adds a combinational forwarding lookup over queue and output stage.
module rfu_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic            clk,
  input logic            reset,
  rfu_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] dest_mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [STV_W-1:0]  starve_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  logic              q_nonempty_s;
  logic              q_full_s;
  logic              starved_s;
  logic              q_win_s;
  logic              alu_win_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] head_dest_s;
  logic [DATA_W-1:0] head_data_s;

  // Grant decision: queue head wins when alone, when the queue is full or when it has waited too long.
  always_comb begin
    q_nonempty_s = (count_r != {CNT_W{1'b0}});
    q_full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    starved_s    = (starve_r == STV_W'(STARVE_LIMIT));
    head_dest_s  = dest_mem_r[rd_ptr_r];
    head_data_s  = data_mem_r[rd_ptr_r];
    if (q_nonempty_s && bus.alu_valid) begin
      q_win_s = q_full_s || starved_s;
    end else begin
      q_win_s = q_nonempty_s;
    end
    alu_win_s = bus.alu_valid && !q_win_s;
    push_s    = bus.mem_valid && !q_full_s;
    pop_s     = q_win_s;
  end

  assign bus.alu_ready = alu_win_s;
  assign bus.mem_ready = !q_full_s;
  assign bus.q_count   = count_r;
  assign bus.busy      = q_nonempty_s || rf_we_r;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;

  // Load-return queue storage and write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dest_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (push_s) begin
      dest_mem_r[wr_ptr_r] <= bus.mem_dest;
      data_mem_r[wr_ptr_r] <= bus.mem_data;
      wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Read pointer and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts ALU wins over a waiting load, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_r <= {STV_W{1'b0}};
    end else if (q_win_s) begin
      starve_r <= {STV_W{1'b0}};
    end else if (alu_win_s && q_nonempty_s && !starved_s) begin
      starve_r <= starve_r + STV_W'(1);
    end
  end

  // Registered write port; x0 destinations are consumed without a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else if (q_win_s) begin
      rf_we_r    <= (head_dest_s != {ADDR_W{1'b0}});
      rf_waddr_r <= head_dest_s;
      rf_wdata_r <= head_data_s;
    end else if (alu_win_s) begin
      rf_we_r    <= (bus.alu_dest != {ADDR_W{1'b0}});
      rf_waddr_r <= bus.alu_dest;
      rf_wdata_r <= bus.alu_data;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

`ifdef RFU_WB_FWD_EN
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;
  logic [PTR_W-1:0]  fwd_idx_s;

  // Forwarding lookup: scan oldest to newest so the youngest match overrides older ones.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    fwd_idx_s  = {PTR_W{1'b0}};
    if (rf_we_r && (rf_waddr_r == bus.fwd_raddr)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = rf_wdata_r;
    end else begin
      fwd_hit_s  = 1'b0;
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_idx_s = rd_ptr_r + PTR_W'(k);
      if ((CNT_W'(k) < count_r) && (dest_mem_r[fwd_idx_s] == bus.fwd_raddr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end
    if (bus.fwd_raddr == {ADDR_W{1'b0}}) begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DATA_W{1'b0}};
    end else begin
      fwd_data_s = fwd_data_s;
    end
  end

  assign bus.fwd_hit  = fwd_hit_s;
  assign bus.fwd_data = fwd_data_s;
`endif
endmodule

// File: tb/tb_rfu_wb_arbiter.sv
// Directed plus randomized bench for rfu_wb_arbiter against a queue-based reference model.
module tb_rfu_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 3;

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rfu_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) bus ();

  rfu_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  entry_t            mq[$];
  int                m_starve;
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic [ADDR_W-1:0] fwd_addr;
  bit                last_alu_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  task automatic check_reset_state();
    chk("rst_q_count", 64'(bus.q_count), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
  endtask

  // One clock of stimulus: checks combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle(input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                       input bit mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat);
    int     n;
    bit     qwin, awin, push;
    entry_t e;
    bus.alu_valid = av;  bus.alu_dest = ad;  bus.alu_data = adat;
    bus.mem_valid = mv;  bus.mem_dest = md;  bus.mem_data = mdat;
`ifdef RFU_WB_FWD_EN
    bus.fwd_raddr = fwd_addr;
`endif
    n = mq.size();
    if (av && n != 0) qwin = (n == DEPTH) || (m_starve == LIMIT);
    else              qwin = (n != 0);
    awin = av && !qwin;
    push = mv && (n != DEPTH);
    @(negedge clk);
    chk("alu_ready", 64'(bus.alu_ready), 64'(awin));
    chk("mem_ready", 64'(bus.mem_ready), 64'(n != DEPTH));
    chk("busy", 64'(bus.busy), 64'((n != 0) || m_we));
`ifdef RFU_WB_FWD_EN
    begin
      bit                f_hit = 1'b0;
      logic [DATA_W-1:0] f_dat = '0;
      if (m_we && m_waddr == fwd_addr) begin f_hit = 1'b1; f_dat = m_wdata; end
      foreach (mq[i]) if (mq[i].dest == fwd_addr) begin f_hit = 1'b1; f_dat = mq[i].data; end
      if (fwd_addr == '0) begin f_hit = 1'b0; f_dat = '0; end
      chk("fwd_hit", 64'(bus.fwd_hit), 64'(f_hit));
      chk("fwd_data", 64'(bus.fwd_data), 64'(f_dat));
    end
`endif
    @(posedge clk);
    #1;
    if (qwin) begin
      e = mq.pop_front();
      m_we = (e.dest != '0); m_waddr = e.dest; m_wdata = e.data;
      m_starve = 0;
    end else if (awin) begin
      m_we = (ad != '0); m_waddr = ad; m_wdata = adat;
      if (n != 0 && m_starve < LIMIT) m_starve++;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.dest = md; e.data = mdat;
      mq.push_back(e);
    end
    last_alu_grant = awin;
    chk("rf_we", 64'(bus.rf_we), 64'(m_we));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
    chk("q_count", 64'(bus.q_count), 64'(mq.size()));
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;
  endtask

  initial begin : stim
    logic              a_pend;
    logic [ADDR_W-1:0] a_dest;
    logic [DATA_W-1:0] a_data;
    fwd_addr = '0;
    reset    = 1'b0;
    idle_inputs();
`ifdef RFU_WB_FWD_EN
    bus.fwd_raddr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;

    // Single ALU write.
    cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("alu7_waddr", 64'(bus.rf_waddr), 64'd7);
    chk("alu7_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Fill the queue while ALU keeps requesting dest 9; the full queue must win next.
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h11);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h22);
    chk("full_q_count", 64'(bus.q_count), 64'd2);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    chk("full_head_addr", 64'(bus.rf_waddr), 64'd3);
    chk("full_head_data", 64'(bus.rf_wdata), 64'h11);
    for (int i = 0; i < 6; i++) cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Starvation: three ALU wins then the load.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
    cycle(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'h0);
    chk("starve_load_addr", 64'(bus.rf_waddr), 64'd5);
    chk("starve_load_data", 64'(bus.rf_wdata), 64'h55);
    cycle(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'h0);
    chk("starve_alu4_addr", 64'(bus.rf_waddr), 64'd4);

    // x0 drops from both paths.
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    chk("x0_alu_we", 64'(bus.rf_we), 64'd0);
    chk("x0_alu_data", 64'(bus.rf_wdata), 64'h1234);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("x0_load_we", 64'(bus.rf_we), 64'd0);
    chk("x0_load_count", 64'(bus.q_count), 64'd0);

    // Forwarding lookup (only meaningful with the feature built in).
    fwd_addr = 5'd6;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hA);
    cycle(1'b1, 5'd8, 32'h8, 1'b1, 5'd6, 32'hB);
    cycle(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'h0);
    fwd_addr = 5'd0;
    cycle(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'h0);

    // Mid-run reset discards queued loads.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAA);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd11, 32'hBB);
    cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hDD);
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Randomized traffic with ALU hold-until-ready.
    a_pend = 1'b0; a_dest = '0; a_data = '0;
    for (int t = 0; t < 400; t++) begin
      if (!a_pend) begin
        a_pend = 1'($urandom_range(0, 1));
        a_dest = 5'($urandom_range(0, 31));
        a_data = $urandom;
      end
      fwd_addr = 5'($urandom_range(0, 7));
      cycle(a_pend, a_dest, a_data, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      if (last_alu_grant) a_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
